mmix_mem_responder: RTL and testbench

- Memory-side responder for the execute unit's load/store request interface (mem_address / mem_datasize / mem_read / mem_write / mem_done).
- Converts each byte/wyde/tetra/octa request into one or two 32-bit Avalon-MM style transactions on the board memory bus (SDRAM/SRAM bridge).
- Handles MMIX big-endian lane placement and size alignment, then returns a single-cycle mem_done pulse to the initiator.

---
 rtl/mmix_mem_pkg.sv | 43 ++++
 rtl/mem_lane_align.sv | 34 +++
 rtl/mmix_mem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_mmix_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmix_mem_pkg.sv
// Shared types for the MMIX memory responder: access sizes, responder states,
// big-endian lane constants and the size-alignment helper.
package mmix_mem_pkg;

  localparam int unsigned TETRA_W = 32;
  localparam int unsigned OCTA_W  = 64;
  localparam int unsigned LANES   = 4;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'd0,
    MEM_WYDE  = 2'd1,
    MEM_TETRA = 2'd2,
    MEM_OCTA  = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_HI_WAIT,
    RD_LO,
    RD_LO_WAIT,
    WR_HI,
    WR_LO,
    DONE
  } resp_state_e;

  // Byteenable bit 3 is the lowest byte address (MSB lane of the tetra).
  localparam logic [LANES-1:0] BE_BYTE0   = 4'b1000;
  localparam logic [LANES-1:0] BE_WYDE_HI = 4'b1100;
  localparam logic [LANES-1:0] BE_WYDE_LO = 4'b0011;
  localparam logic [LANES-1:0] BE_ALL     = 4'b1111;

  function automatic logic [OCTA_W-1:0] align_addr(input logic [OCTA_W-1:0] addr,
                                                   input mem_size_e size);
    case (size)
      MEM_BYTE:  return addr;
      MEM_WYDE:  return {addr[OCTA_W-1:1], 1'b0};
      MEM_TETRA: return {addr[OCTA_W-1:2], 2'b00};
      default:   return {addr[OCTA_W-1:3], 3'b000};
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane mapping for one tetra: byteenables, replicated write data and
// right-justified read extraction for a given size and in-tetra offset.
module mem_lane_align
  import mmix_mem_pkg::*;
(
  input  mem_size_e            size,
  input  logic [1:0]           offset,
  input  logic [TETRA_W-1:0]   wr_src,
  input  logic [TETRA_W-1:0]   rd_tetra,
  output logic [LANES-1:0]     byteenable_c,
  output logic [TETRA_W-1:0]   wr_tetra_c,
  output logic [TETRA_W-1:0]   rd_data_c
);

  always_comb begin
    byteenable_c = BE_ALL;
    wr_tetra_c   = wr_src;
    rd_data_c    = rd_tetra;
    case (size)
      MEM_BYTE: begin
        byteenable_c = BE_BYTE0 >> offset;
        wr_tetra_c   = {4{wr_src[7:0]}};
        rd_data_c    = TETRA_W'(8'(rd_tetra >> {~offset, 3'b000}));
      end
      MEM_WYDE: begin
        byteenable_c = offset[1] ? BE_WYDE_LO : BE_WYDE_HI;
        wr_tetra_c   = {2{wr_src[15:0]}};
        rd_data_c    = offset[1] ? {16'h0, rd_tetra[15:0]} : {16'h0, rd_tetra[31:16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmix_mem_responder.sv
// Converts MMIX byte/wyde/tetra/octa load-store requests into 32-bit Avalon-MM
// cycles. Optional range fault on upper address bits: MMIX_MEM_RANGE_CHECK_EN.
module mmix_mem_responder
  import mmix_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 23,
  parameter int unsigned READ_TO_DONE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OCTA_W-1:0]   mem_address,
  input  logic [1:0]          mem_datasize,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [OCTA_W-1:0]   mem_writedata,
  output logic [OCTA_W-1:0]   mem_readdata,
  output logic                mem_done,
  output logic                mem_error,
  output logic [31:0]         bus_address,
  output logic                bus_read,
  output logic                bus_write,
  output logic [LANES-1:0]    bus_byteenable,
  output logic [TETRA_W-1:0]  bus_writedata,
  input  logic [TETRA_W-1:0]  bus_readdata,
  input  logic                bus_readdatavalid,
  input  logic                bus_waitrequest
);

  resp_state_e          state, nxt;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  mem_size_e            size_q, size_d;
  logic [TETRA_W-1:0]   wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic                 cnt_q, cnt_d;

  logic [OCTA_W-1:0]    rdata_d;
  logic [31:0]          bus_address_d;
  logic                 bus_read_d, bus_write_d;
  logic [LANES-1:0]     be_d;
  logic [TETRA_W-1:0]   bwd_d;
  logic                 done_d, error_d;

  logic                 req_c;
  mem_size_e            req_size_c;
  logic [OCTA_W-1:0]    req_aligned_c;
  logic                 range_err_c;
  logic [31:0]          lo_addr_c;

  mem_size_e            la_size;
  logic [1:0]           la_off;
  logic [TETRA_W-1:0]   la_wsrc;
  logic [LANES-1:0]     la_be_c;
  logic [TETRA_W-1:0]   la_wr_c;
  logic [TETRA_W-1:0]   la_rd_c;

  assign req_c         = mem_read | mem_write;
  assign req_size_c    = mem_size_e'(mem_datasize);
  assign req_aligned_c = align_addr(mem_address, req_size_c);
  assign lo_addr_c     = 32'({addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00});

`ifdef MMIX_MEM_RANGE_CHECK_EN
  // Bit 63 is the kernel-space flag and never faults.
  assign range_err_c = |req_aligned_c[OCTA_W-2:ADDR_W];
`else
  assign range_err_c = 1'b0;
`endif

  // In IDLE the lanes are computed from the incoming request so the first
  // command can be registered on the sampling edge.
  always_comb begin
    if (state == IDLE) begin
      la_size = req_size_c;
      la_off  = req_aligned_c[1:0];
      la_wsrc = (req_size_c == MEM_OCTA) ? mem_writedata[63:32] : mem_writedata[31:0];
    end else begin
      la_size = size_q;
      la_off  = addr_q[1:0];
      la_wsrc = wdata_q;
    end
  end

  mem_lane_align u_lane (
    .size         (la_size),
    .offset       (la_off),
    .wr_src       (la_wsrc),
    .rd_tetra     (bus_readdata),
    .byteenable_c (la_be_c),
    .wr_tetra_c   (la_wr_c),
    .rd_data_c    (la_rd_c)
  );

  always_comb begin
    nxt           = state;
    addr_d        = addr_q;
    size_d        = size_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    rdata_d       = mem_readdata;
    bus_address_d = bus_address;
    bus_read_d    = bus_read;
    bus_write_d   = bus_write;
    be_d          = bus_byteenable;
    bwd_d         = bus_writedata;
    done_d        = 1'b0;
    error_d       = 1'b0;

    case (state)
      IDLE: begin
        if (req_c) begin
          addr_d  = req_aligned_c[ADDR_W-1:0];
          size_d  = req_size_c;
          wdata_d = mem_writedata[31:0];
          err_d   = range_err_c;
          rdata_d = '0;
          if (range_err_c) begin
            nxt = DONE;
          end else begin
            bus_address_d = 32'({req_aligned_c[ADDR_W-1:2], 2'b00});
            be_d          = la_be_c;
            bwd_d         = la_wr_c;
            if (mem_read) begin
              bus_read_d = 1'b1;
              nxt        = RD_HI;
            end else begin
              bus_write_d = 1'b1;
              nxt         = WR_HI;
            end
          end
        end
      end
      RD_HI: begin
        if (!bus_waitrequest) begin
          bus_read_d = 1'b0;
          nxt        = RD_HI_WAIT;
        end
      end
      RD_HI_WAIT: begin
        if (bus_readdatavalid) begin
          if (size_q == MEM_OCTA) begin
            rdata_d[63:32] = la_rd_c;
            bus_read_d     = 1'b1;
            bus_address_d  = lo_addr_c;
            nxt            = RD_LO;
          end else begin
            rdata_d = {32'h0, la_rd_c};
            nxt     = DONE;
          end
        end
      end
      RD_LO: begin
        if (!bus_waitrequest) begin
          bus_read_d = 1'b0;
          nxt        = RD_LO_WAIT;
        end
      end
      RD_LO_WAIT: begin
        if (bus_readdatavalid) begin
          rdata_d[31:0] = la_rd_c;
          nxt           = DONE;
        end
      end
      WR_HI: begin
        if (!bus_waitrequest) begin
          if (size_q == MEM_OCTA) begin
            bus_address_d = lo_addr_c;
            bwd_d         = la_wr_c;
            nxt           = WR_LO;
          end else begin
            bus_write_d = 1'b0;
            nxt         = DONE;
          end
        end
      end
      WR_LO: begin
        if (!bus_waitrequest) begin
          bus_write_d = 1'b0;
          nxt         = DONE;
        end
      end
      DONE: begin
        if (!cnt_q) nxt = IDLE;
        else        cnt_d = 1'b0;
      end
      default: nxt = IDLE;
    endcase

    // DONE lasts READ_TO_DONE cycles; mem_done marks the last of them.
    if (nxt == DONE && state != DONE) cnt_d = 1'(READ_TO_DONE - 1);
    done_d  = (nxt == DONE) && !cnt_d;
    error_d = done_d && err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr_q         <= '0;
      size_q         <= MEM_BYTE;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      cnt_q          <= 1'b0;
      mem_readdata   <= '0;
      mem_done       <= 1'b0;
      mem_error      <= 1'b0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_byteenable <= '0;
      bus_writedata  <= '0;
    end else begin
      state          <= nxt;
      addr_q         <= addr_d;
      size_q         <= size_d;
      wdata_q        <= wdata_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
      mem_readdata   <= rdata_d;
      mem_done       <= done_d;
      mem_error      <= error_d;
      bus_address    <= bus_address_d;
      bus_read       <= bus_read_d;
      bus_write      <= bus_write_d;
      bus_byteenable <= be_d;
      bus_writedata  <= bwd_d;
    end
  end

endmodule

// File: tb/tb_mmix_mem_responder.sv
// Randomized bench for mmix_mem_responder: byte-level reference memory model,
// Avalon slave with random waitrequest/latency, directed boundary cases.
module tb_mmix_mem_responder;

  localparam int unsigned ADDR_W = 23;
  localparam logic [31:0] PMASK  = 32'h007F_FFFF;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] mem_address = '0;
  logic [1:0]  mem_datasize = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [63:0] mem_writedata = '0;
  logic [63:0] mem_readdata;
  logic        mem_done, mem_error;
  logic [31:0] bus_address;
  logic        bus_read, bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata = '0;
  logic        bus_readdatavalid = 1'b0;
  logic        bus_waitrequest = 1'b0;

  always #5 clk = ~clk;

  mmix_mem_responder #(.ADDR_W(ADDR_W), .READ_TO_DONE(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_address       (mem_address),
    .mem_datasize      (mem_datasize),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata),
    .mem_done          (mem_done),
    .mem_error         (mem_error),
    .bus_address       (bus_address),
    .bus_read          (bus_read),
    .bus_write         (bus_write),
    .bus_byteenable    (bus_byteenable),
    .bus_writedata     (bus_writedata),
    .bus_readdata      (bus_readdata),
    .bus_readdatavalid (bus_readdatavalid),
    .bus_waitrequest   (bus_waitrequest)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference memory (bytes) and slave memory (tetras) start from the same hash.
  logic [7:0]  rb   [int unsigned];
  logic [31:0] smem [int unsigned];

  function automatic logic [31:0] hash_t(input int unsigned ta);
    return (ta * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [7:0] ref_byte(input int unsigned a);
    logic [31:0] t;
    if (rb.exists(a)) return rb[a];
    t = hash_t(a & ~32'd3);
    return 8'(t >> (8 * (3 - (a % 4))));
  endfunction

  function automatic logic [31:0] slv_get(input int unsigned ta);
    if (smem.exists(ta)) return smem[ta];
    return hash_t(ta);
  endfunction

  // Avalon slave model: decides waitrequest mid-cycle, records accepted commands.
  int          wait_pct = 0;
  int          force_wait = 0;
  int          lat_fixed = 1;
  int          pend_cnt = 0;
  int unsigned pend_addr = 0;
  tx_t         obs[$];
  bit          hold_pending = 1'b0;
  logic [37:0] hold_cmd;
  logic [31:0] hold_wd;

  always @(negedge clk) begin
    logic        cmd;
    logic [31:0] t;
    tx_t         rec;
    bus_readdatavalid = 1'b0;
    bus_readdata      = $urandom;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus_readdatavalid = 1'b1;
        bus_readdata      = slv_get(pend_addr);
      end
    end
    if (hold_pending) begin
      check_eq("hold_cmd", {bus_read, bus_write, bus_byteenable, bus_address}, hold_cmd);
      if (bus_write) check_eq("hold_wdata", bus_writedata, hold_wd);
      hold_pending = 1'b0;
    end
    cmd = bus_read | bus_write;
    if (force_wait > 0 && cmd) begin
      bus_waitrequest = 1'b1;
      force_wait--;
    end else begin
      bus_waitrequest = (wait_pct > 0) && ($urandom_range(99) < wait_pct);
    end
    if (cmd && bus_waitrequest) begin
      hold_pending = 1'b1;
      hold_cmd     = {bus_read, bus_write, bus_byteenable, bus_address};
      hold_wd      = bus_writedata;
    end
    if (cmd && !bus_waitrequest) begin
      rec = '{wr: bus_write, addr: bus_address, be: bus_byteenable, data: bus_writedata};
      obs.push_back(rec);
      if (bus_read) begin
        check_eq("one_outstanding", pend_cnt, 0);
        pend_cnt  = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 3);
        pend_addr = bus_address;
      end else begin
        t = slv_get(bus_address);
        for (int l = 0; l < 4; l++)
          if (bus_byteenable[l]) t[8*l +: 8] = bus_writedata[8*l +: 8];
        smem[bus_address] = t;
      end
    end
  end

  // One request through the reference model and the DUT; entered just after a negedge.
  task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [1:0] sz, input logic [63:0] wd, input int exp_cyc);
    int          nb, ntx, cycles, idx;
    logic [63:0] al, exp_rd;
    int unsigned phys, ba;
    logic        exp_err, is_wr, done;
    logic [31:0] e_addr [2];
    logic [3:0]  e_be   [2];
    logic [31:0] e_wd   [2];

    nb    = 1 << sz;
    al    = addr & ~(64'(nb) - 64'd1);
    phys  = 32'(al[ADDR_W-1:0]);
    is_wr = !rd && wr;
`ifdef MMIX_MEM_RANGE_CHECK_EN
    exp_err = |al[62:ADDR_W];
`else
    exp_err = 1'b0;
`endif
    exp_rd = '0;
    ntx    = 0;
    if (!exp_err) begin
      for (int i = 0; i < nb; i++) exp_rd = (exp_rd << 8) | 64'(ref_byte((phys + i) & PMASK));
      ntx = (sz == 2'd3) ? 2 : 1;
      for (int t = 0; t < ntx; t++) begin
        e_addr[t] = ((phys & ~32'd3) + 32'(4 * t)) & PMASK;
        e_be[t]   = '0;
        for (int i = 0; i < nb; i++) begin
          ba = (phys + i) & PMASK;
          if ((ba & ~32'd3) == e_addr[t]) begin
            idx = 3 - int'(ba % 4);
            e_be[t][idx] = 1'b1;
          end
        end
        case (sz)
          2'd0:    e_wd[t] = {4{wd[7:0]}};
          2'd1:    e_wd[t] = {2{wd[15:0]}};
          2'd2:    e_wd[t] = wd[31:0];
          default: e_wd[t] = (t == 0) ? wd[63:32] : wd[31:0];
        endcase
      end
      if (is_wr)
        for (int i = 0; i < nb; i++) rb[(phys + i) & PMASK] = 8'(wd >> (8 * (nb - 1 - i)));
    end

    obs.delete();
    mem_address   = addr;
    mem_datasize  = sz;
    mem_writedata = wd;
    mem_read      = rd;
    mem_write     = wr;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (mem_done) done = 1'b1;
    end
    check_eq("done_seen", done, 1'b1);
    if (exp_cyc >= 0) check_eq("latency", cycles, exp_cyc);
    check_eq("error", mem_error, exp_err);
    if (rd) check_eq("rdata", mem_readdata, exp_rd);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", mem_done, 1'b0);
    if (rd) check_eq("rdata_hold", mem_readdata, exp_rd);
    check_eq("ntx", obs.size(), ntx);
    for (int t = 0; t < ntx && t < obs.size(); t++) begin
      check_eq("tx_addr", obs[t].addr, e_addr[t]);
      check_eq("tx_be", obs[t].be, e_be[t]);
      check_eq("tx_kind", obs[t].wr, is_wr);
      if (is_wr) check_eq("tx_wdata", obs[t].data, e_wd[t]);
    end
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic [63:0] a, hi;
    logic [1:0]  k;

    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {bus_read, bus_write, mem_done, mem_error, bus_byteenable}, '0);
    check_eq("rst_addr", bus_address, '0);
    check_eq("rst_rdata", mem_readdata, '0);
    check_eq("rst_wdata", bus_writedata, '0);
    reset = 1'b0;
    @(negedge clk);

    do_req(1'b0, 1'b1, 64'h1000, 2'd3, 64'h0123_4567_89AB_CDEF, 3);
    do_req(1'b1, 1'b0, 64'h1003, 2'd0, 64'h0, 3);
    do_req(1'b0, 1'b1, 64'h2003, 2'd1, 64'hFFFF_BEEF, 2);
    force_wait = 5;
    do_req(1'b1, 1'b0, 64'h1000, 2'd3, 64'h0, 10);
    do_req(1'b1, 1'b0, 64'h1000, 2'd2, 64'h0, 3);
    do_req(1'b1, 1'b1, 64'h1004, 2'd2, 64'hAAAA_5555_AAAA_5555, 3);

    // Reset while the low tetra of an octa read is outstanding.
    lat_fixed = 6;
    obs.delete();
    mem_address  = 64'h1000;
    mem_datasize = 2'd3;
    mem_read     = 1'b1;
    cyc = 0;
    while (obs.size() < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_reach_lo", obs.size(), 2);
    @(negedge clk);
    reset    = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_outs", {bus_read, bus_write, mem_done}, 3'b000);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_done) seen = 1'b1;
    end
    check_eq("rst_no_done", seen, 1'b0);
    lat_fixed = 1;
    do_req(1'b1, 1'b0, 64'h1004, 2'd2, 64'h0, 3);

`ifdef MMIX_MEM_RANGE_CHECK_EN
    do_req(1'b1, 1'b0, 64'h80_0000, 2'd2, 64'h0, 1);
`else
    do_req(1'b1, 1'b0, 64'h80_0000, 2'd2, 64'h0, 3);
`endif
    do_req(1'b1, 1'b0, 64'h8000_0000_0000_1000, 2'd2, 64'h0, 3);

    lat_fixed = 0;
    for (int n = 0; n < 150; n++) begin
      wait_pct = ($urandom_range(1) == 0) ? 30 : 0;
      k  = 2'($urandom_range(3));
      a  = 64'h3000 + 64'($urandom_range(255));
      hi = {$urandom, $urandom};
      if ($urandom_range(4) == 0) a = a | (hi & 64'h7FFF_FFFF_FF80_0000);
      if ($urandom_range(4) == 0) a[63] = 1'b1;
      case ($urandom_range(2))
        0:       do_req(1'b1, 1'b0, a, k, {$urandom, $urandom}, -1);
        1:       do_req(1'b0, 1'b1, a, k, {$urandom, $urandom}, -1);
        default: do_req(1'b1, 1'b1, a, k, {$urandom, $urandom}, -1);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
